// File: rtl/imm_extend_pipe.sv
// Configurable sign/zero/upper immediate extender; upper mode built only with IMM_EXT_UPPER_EN.
// Latency: 1 cycle from input transfer to o_valid; full throughput with i_ready high.
// Backpressure: 2-entry main+skid buffer, o_ready registered and low only when both are full.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [IN_W-1:0]  i_data,
   input  logic [1:0]       i_mode,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_data,
   output logic             o_illegal
);

   localparam int K = OUT_W - IN_W;

   typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;

   state_t             state_q, state_d;
   logic [OUT_W-1:0]   main_data_q, main_data_d;
   logic               main_ill_q, main_ill_d;
   logic [OUT_W-1:0]   skid_data_q, skid_data_d;
   logic               skid_ill_q, skid_ill_d;
   logic               vld_q, vld_d;
   logic               rdy_q, rdy_d;

   logic [OUT_W-1:0]   sign_data, zero_data, ext_data;
   logic               ext_ill;
   logic               accept, drain;

   assign sign_data = {{K{i_data[IN_W-1]}}, i_data};
   assign zero_data = {{K{1'b0}}, i_data};

   // Reserved modes (and upper mode when not built) fall back to sign extension.
   always_comb begin
      ext_data = sign_data;
      ext_ill  = 1'b0;
      case (i_mode)
         2'b00: ext_data = sign_data;
         2'b01: ext_data = zero_data;
`ifdef IMM_EXT_UPPER_EN
         2'b10: ext_data = zero_data << K;
`endif
         default: ext_ill = 1'b1;
      endcase
   end

   assign accept = i_valid && rdy_q;
   assign drain  = vld_q && i_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ill_d  = main_ill_q;
      skid_data_d = skid_data_q;
      skid_ill_d  = skid_ill_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_data_d = ext_data;
               main_ill_d  = ext_ill;
               state_d     = FULL1;
            end
         end
         FULL1: begin
            if (accept && drain) begin
               main_data_d = ext_data;
               main_ill_d  = ext_ill;
            end else if (accept) begin
               skid_data_d = ext_data;
               skid_ill_d  = ext_ill;
               state_d     = FULL2;
            end else if (drain) begin
               state_d     = EMPTY;
            end
         end
         FULL2: begin
            if (drain) begin
               main_data_d = skid_data_q;
               main_ill_d  = skid_ill_q;
               state_d     = FULL1;
            end
         end
         default: state_d = EMPTY;
      endcase
      vld_d = (state_d != EMPTY);
      rdy_d = (state_d != FULL2);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ill_q  <= 1'b0;
         skid_data_q <= '0;
         skid_ill_q  <= 1'b0;
         vld_q       <= 1'b0;
         rdy_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ill_q  <= main_ill_d;
         skid_data_q <= skid_data_d;
         skid_ill_q  <= skid_ill_d;
         vld_q       <= vld_d;
         rdy_q       <= rdy_d;
      end
   end

   assign o_valid   = vld_q;
   assign o_ready   = rdy_q;
   assign o_data    = main_data_q;
   assign o_illegal = main_ill_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed vectors plus a randomized stream
// compared against a queue-based reference model.
module tb_imm_extend_pipe;
   localparam int IN_W  = 16;
   localparam int OUT_W = 32;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_valid;
   logic             o_ready;
   logic [IN_W-1:0]  i_data;
   logic [1:0]       i_mode;
   logic             o_valid;
   logic             i_ready;
   logic [OUT_W-1:0] o_data;
   logic             o_illegal;

   int checks = 0;
   int errors = 0;

   imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Reference: result as plain arithmetic modulo 2^OUT_W, bit 32 = illegal flag.
   function automatic logic [OUT_W:0] ref_ext(input logic [IN_W-1:0] d, input logic [1:0] m);
      longint v;
      longint r;
      logic   ill;
      v   = longint'(d);
      ill = (m == 2'd3);
`ifdef IMM_EXT_UPPER_EN
      if (m == 2'd2) r = v * (64'd1 << (OUT_W - IN_W));
      else
`else
      if (m == 2'd2) ill = 1'b1;
`endif
      if (m == 2'd1) r = v;
      else if (m != 2'd2 || ill) r = (v >= (64'd1 << (IN_W - 1))) ? v - (64'd1 << IN_W) : v;
      return {ill, r[OUT_W-1:0]};
   endfunction

   task automatic flush();
      i_valid = 1'b0;
      i_ready = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0; i_data = 16'hABCD; i_mode = 2'b00;
      repeat (2) tick();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 32'h0 || o_illegal !== 1'b0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: got vld=%b data=%h ill=%b rdy=%b, expected 0 00000000 0 1",
                  o_valid, o_data, o_illegal, o_ready);
      end
      i_rst = 1'b0; i_valid = 1'b0;
      tick();
   endtask

   task automatic test_modes();
      logic [IN_W-1:0]  vd [5] = '{16'hF123, 16'h7321, 16'hF123, 16'h8000, 16'h1234};
      logic [1:0]       vm [5] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
`ifdef IMM_EXT_UPPER_EN
      logic [OUT_W-1:0] ve [5] = '{32'hFFFFF123, 32'h00007321, 32'h0000F123, 32'hFFFF8000, 32'h12340000};
      logic             vi [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
      logic [OUT_W-1:0] ve [5] = '{32'hFFFFF123, 32'h00007321, 32'h0000F123, 32'hFFFF8000, 32'h00001234};
      logic             vi [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
      for (int i = 0; i < 5; i++) begin
         i_ready = 1'b1; i_valid = 1'b1; i_data = vd[i]; i_mode = vm[i];
         tick();
         i_valid = 1'b0;
         checks++;
         if (o_valid !== 1'b1 || o_data !== ve[i] || o_illegal !== vi[i]) begin
            errors++;
            $display("FAIL mode%0d vec%0d: got vld=%b data=%h ill=%b, expected 1 %h %b",
                     vm[i], i, o_valid, o_data, o_illegal, ve[i], vi[i]);
         end
         tick();
         checks++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain vec%0d: got vld=%b, expected 0", i, o_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int n_sent = 0, n_out = 0, cyc = 0;
      logic acc, drn;
      i_ready = 1'b0; i_mode = 2'b00; i_valid = 1'b1; i_data = 16'd1;
      tick(); n_sent = 1;
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'd1 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first: got vld=%b data=%h rdy=%b, expected 1 00000001 1", o_valid, o_data, o_ready);
      end
      i_data = 16'd2;
      tick(); n_sent = 2;
      i_data = 16'd3;
      checks++;
      if (o_ready !== 1'b0 || o_data !== 32'd1) begin
         errors++;
         $display("FAIL bp_full: got rdy=%b data=%h, expected 0 00000001", o_ready, o_data);
      end
      for (int s = 0; s < 2; s++) begin
         tick();
         checks++;
         if (o_data !== 32'd1 || o_valid !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got data=%h vld=%b rdy=%b, expected 00000001 1 0", s, o_data, o_valid, o_ready);
         end
      end
      i_ready = 1'b1;
      while (n_out < 5 && cyc < 40) begin
         i_valid = (n_sent < 5);
         i_data  = 16'(n_sent + 1);
         acc = i_valid && o_ready;
         drn = o_valid && i_ready;
         if (drn) begin
            checks++;
            if (o_data !== 32'(n_out + 1)) begin
               errors++;
               $display("FAIL bp_order%0d: got %h, expected %h", n_out, o_data, 32'(n_out + 1));
            end
         end
         tick();
         if (acc) n_sent++;
         if (drn) n_out++;
         cyc++;
      end
      i_valid = 1'b0;
      checks++;
      if (n_out != 5 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_count: got %0d outputs vld=%b, expected 5 outputs vld=0", n_out, o_valid);
      end
   endtask

   task automatic test_throughput();
      logic [IN_W-1:0] base;
      logic [OUT_W:0]  e;
      base = 16'($urandom);
      i_ready = 1'b1; i_mode = 2'b00;
      for (int i = 0; i < 8; i++) begin
         i_valid = 1'b1;
         i_data  = base + 16'(i);
         tick();
         e = ref_ext(base + 16'(i), 2'b00);
         checks++;
         if (o_valid !== 1'b1 || o_data !== e[OUT_W-1:0] || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL thru%0d: got vld=%b data=%h rdy=%b, expected 1 %h 1",
                     i, o_valid, o_data, o_ready, e[OUT_W-1:0]);
         end
      end
      i_valid = 1'b0;
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL thru_end: got vld=%b, expected 0", o_valid);
      end
   endtask

   task automatic test_reset_full2();
      i_ready = 1'b0; i_mode = 2'b01; i_valid = 1'b1;
      i_data = 16'h1111; tick();
      i_data = 16'h2222; tick();
      checks++;
      if (o_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_pre: got rdy=%b, expected 0", o_ready);
      end
      i_rst = 1'b1; i_ready = 1'b1; i_data = 16'h3333;
      tick();
      i_rst = 1'b0; i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_data !== 32'h0 || o_ready !== 1'b1 || o_illegal !== 1'b0) begin
         errors++;
         $display("FAIL rst_full2: got vld=%b data=%h rdy=%b ill=%b, expected 0 00000000 1 0",
                  o_valid, o_data, o_ready, o_illegal);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale%0d: got vld=%b data=%h, expected vld 0", i, o_valid, o_data);
         end
      end
   endtask

   task automatic test_random();
      logic [OUT_W:0] q[$];
      logic acc, drn;
      for (int c = 0; c < 400; c++) begin
         i_valid = ($urandom_range(0, 3) != 0);
         i_ready = ($urandom_range(0, 2) != 0);
         i_data  = 16'($urandom);
         i_mode  = 2'($urandom_range(0, 3));
         checks++;
         if (o_valid !== (q.size() > 0) || o_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL rnd_ctl c%0d: got vld=%b rdy=%b, expected vld=%b rdy=%b",
                     c, o_valid, o_ready, q.size() > 0, q.size() < 2);
         end
         if (q.size() > 0) begin
            checks++;
            if ({o_illegal, o_data} !== q[0]) begin
               errors++;
               $display("FAIL rnd_data c%0d: got ill=%b data=%h, expected ill=%b data=%h",
                        c, o_illegal, o_data, q[0][OUT_W], q[0][OUT_W-1:0]);
            end
         end
         acc = i_valid && o_ready;
         drn = o_valid && i_ready;
         tick();
         if (drn && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back(ref_ext(i_data, i_mode));
      end
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0; i_mode = '0;
      test_reset();
      test_modes();
      flush();
      test_backpressure();
      flush();
      test_throughput();
      flush();
      test_reset_full2();
      flush();
      test_random();
      flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
